// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction memory and registers each word with its PC.
// Latency: an instruction appears on inst_o/pc_o one cycle after its PC drives imem_addr.
// Backpressure: a single-entry output register; while out_valid & !out_ready, pc and outputs hold.
module inst_fetch_unit #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_dout,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              fault,
  output logic [31:0]       fault_pc
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [31:0] inst_nxt, pc_o_nxt;
  logic        fault_nxt;
  logic [31:0] fault_pc_nxt;

  logic accept;
  logic slot_free;

  // An address is unusable if it is not word aligned or lies beyond the memory depth.
  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  assign imem_addr = pc[ADDR_W+1:2];
  assign accept    = out_valid & out_ready;
  assign slot_free = !out_valid | accept;

  // State register and all architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      pc        <= RESET_VEC;
      out_valid <= 1'b0;
      inst_o    <= NOP_INST;
      pc_o      <= 32'h0;
      fault     <= 1'b0;
      fault_pc  <= 32'h0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      inst_o    <= inst_nxt;
      pc_o      <= pc_o_nxt;
      fault     <= fault_nxt;
      fault_pc  <= fault_pc_nxt;
    end
  end

  // Next-state logic: redirect beats fault detection beats halt beats capture.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    valid_nxt    = out_valid;
    inst_nxt     = inst_o;
    pc_o_nxt     = pc_o;
    fault_nxt    = fault;
    fault_pc_nxt = fault_pc;

    case (state)
      S_WAIT: begin
        state_nxt = S_RUN;
      end

      S_RUN: begin
        if (redirect_valid) begin
          // Flush whatever is held, even if it is being accepted right now.
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          if (is_bad(redirect_pc)) begin
            state_nxt    = S_FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = redirect_pc;
          end
        end else if (is_bad(pc)) begin
          // A held instruction is still good; let the consumer take it.
          state_nxt    = S_FAULT;
          fault_nxt    = 1'b1;
          fault_pc_nxt = pc;
          if (slot_free) valid_nxt = 1'b0;
        end else if (halt_i) begin
          state_nxt = S_HALT;
          if (accept) valid_nxt = 1'b0;
        end else if (slot_free) begin
          inst_nxt  = imem_dout;
          pc_o_nxt  = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + 32'd4;
        end
      end

      S_HALT: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
        end else if (accept) begin
          valid_nxt = 1'b0;
        end
        if (redirect_valid && is_bad(redirect_pc)) begin
          state_nxt    = S_FAULT;
          fault_nxt    = 1'b1;
          fault_pc_nxt = redirect_pc;
        end else if (!halt_i) begin
          state_nxt = S_RUN;
        end
      end

      S_FAULT: begin
        if (accept) valid_nxt = 1'b0;
      end

      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed stimulus, a cycle model of the fetch rules and literal spot checks.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] imem [0:4095];
  assign imem_dout = imem[imem_addr];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_i        (halt_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:14] != 18'h0);
  endfunction

  // ---------------- reference model ----------------
  // mode: 0 = one idle cycle after reset, 1 = fetching, 2 = halted, 3 = faulted
  int          m_mode  = 0;
  logic [31:0] m_pc    = 32'h0;
  bit          m_valid = 1'b0;
  logic [31:0] m_inst  = 32'h13;
  logic [31:0] m_pco   = 32'h0;
  bit          m_fault = 1'b0;
  logic [31:0] m_fpc   = 32'h0;

  task automatic model_trap(input logic [31:0] a);
    m_mode  = 3;
    m_fault = 1'b1;
    m_fpc   = a;
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit took, room;
    if (!rst_n) begin
      m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h13;
      m_pco = 32'h0; m_fault = 1'b0; m_fpc = 32'h0;
    end else begin
      took = m_valid && out_ready;
      room = !m_valid || took;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 3) begin
        if (took) m_valid = 1'b0;
      end else if ((m_mode == 1 || m_mode == 2) && redirect_valid) begin
        m_valid = 1'b0;
        m_pc    = redirect_pc;
        if (bad_addr(redirect_pc)) model_trap(redirect_pc);
        else if (m_mode == 2 && !halt_i) m_mode = 1;
      end else if (m_mode == 2) begin
        if (took) m_valid = 1'b0;
        if (!halt_i) m_mode = 1;
      end else if (bad_addr(m_pc)) begin
        model_trap(m_pc);
        if (room) m_valid = 1'b0;
      end else if (halt_i) begin
        m_mode = 2;
        if (took) m_valid = 1'b0;
      end else if (room) begin
        m_inst  = imem[m_pc[13:2]];
        m_pco   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model, plus an independent check that
  // every valid output word is the memory content at its own PC.
  always @(negedge clk) begin
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    chk("fault", {31'h0, fault}, {31'h0, m_fault});
    chk("fault_pc", fault_pc, m_fpc);
    chk("imem_addr", {20'h0, imem_addr}, {20'h0, m_pc[13:2]});
    if (m_valid || !rst_n) begin
      chk("pc_o", pc_o, m_pco);
      chk("inst_o", inst_o, m_inst);
    end
    if (out_valid && !bad_addr(pc_o))
      chk("inst_matches_mem", inst_o, imem[pc_o[13:2]]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] last_pco;
  int          budget;

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = 32'h100 + i;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt_i = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0000_0013);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_imem_addr", {20'h0, imem_addr}, 32'h0);

    // Sequential fetch
    rst_n = 1'b1;
    tick();
    chk("wait_no_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("seq0_pc", pc_o, 32'h0);
    chk("seq0_inst", inst_o, 32'h100);
    tick();
    chk("seq1_pc", pc_o, 32'h4);
    chk("seq1_inst", inst_o, 32'h101);

    // Stall three cycles on pc_o=4
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_o, 32'h4);
      chk("stall_inst", inst_o, 32'h101);
      chk("stall_addr", {20'h0, imem_addr}, 32'h2);
    end
    out_ready = 1'b1;
    tick();
    chk("after_stall_pc", pc_o, 32'h8);
    chk("after_stall_inst", inst_o, 32'h102);

    // Redirect while pc_o=8 is held and not accepted
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("redir_flush", {31'h0, out_valid}, 32'h0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("redir_pc", pc_o, 32'h40);
    chk("redir_inst", inst_o, 32'h110);

    // Halt for four cycles
    halt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_no_valid", {31'h0, out_valid}, 32'h0);
      chk("halt_pc_o", pc_o, 32'h40);
    end
    halt_i = 1'b0;
    tick();
    chk("unhalt_idle", {31'h0, out_valid}, 32'h0);
    tick();
    chk("resume_pc", pc_o, 32'h44);
    chk("resume_inst", inst_o, 32'h111);

    // Misaligned redirect traps; later redirects are ignored
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_fault_pc", fault_pc, 32'h42);
    chk("mis_valid", {31'h0, out_valid}, 32'h0);
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    chk("fault_sticky", {31'h0, fault}, 32'h1);
    chk("fault_pc_kept", fault_pc, 32'h42);
    chk("fault_no_fetch", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset clears the fault without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst_fault", {31'h0, fault}, 32'h0);
    chk("async_rst_fault_pc", fault_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Out-of-range: jump near the top of memory and fetch sequentially off the end
    redirect_valid = 1'b1; redirect_pc = 32'h3FF0;
    tick();
    redirect_valid = 1'b0;
    last_pco = 32'hFFFF_FFFF;
    budget = 40;
    while (!fault && budget > 0) begin
      tick();
      if (out_valid) last_pco = pc_o;
      budget--;
    end
    chk("oor_reached", {31'h0, fault}, 32'h1);
    chk("oor_fault_pc", fault_pc, 32'h4000);
    chk("oor_last_pc_o", last_pco, 32'h3FFC);
    chk("oor_valid", {31'h0, out_valid}, 32'h0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
